mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit.
- Consumes the EX/MEM pipeline register outputs: address (ALU result), store data, destination register, and control bits.
- Drives a single-outstanding request/acknowledge data-memory bus and stalls the pipeline while an access is in flight.
- Returns aligned, sign/zero-extended load data with its destination register for the MEM/WB register.

---
 rtl/mem_stage_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- memory-stage load/store unit.
//
// Takes the EX/MEM register outputs, runs one access at a time on a
// request/acknowledge data bus, holds the pipeline while the access is in
// flight, and hands aligned, extended load data to the MEM/WB register.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   : misaligned H/W accesses are refused
//                                     (no bus cycle, no stall) and misalign_o
//                                     pulses in the following cycle.
//                         undefined : misalign_o is tied 0 and misaligned
//                                     accesses use the natural boundary
//                                     (H -> addr[1], W -> offset 00).
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   valid_m, mem_read_m,
//   mem_write_m, funct3_m          MEM-stage instruction and access type
//   alu_result_m, data_w_m, rd_m   byte address, store data, destination reg
//   stall_o                        freeze IF..MEM while an access is pending
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be              data bus request (held stable in BUSY)
//   mem_ack, mem_rdata             data bus response
//   wb_valid_o, wb_data_o, wb_rd_o load result for writeback (one-cycle pulse)
//   misalign_o                     misaligned-access pulse
module mem_stage_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // lane logic below assumes 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [ADDR_W-1:0] alu_result_m,
  input  logic [DATA_W-1:0] data_w_m,
  input  logic [4:0]        rd_m,
  output logic              stall_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  // Access decode from the EX/MEM register. funct3[1:0]: 00 B, 01 H, else W.
  logic        start;
  logic        take;
  logic [1:0]  size;
  logic [1:0]  eff_off;
  logic [3:0]  be_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ld_data;

  assign start = valid_m & (mem_read_m | mem_write_m);
  assign size  = funct3_m[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size == 2'b01) & alu_result_m[0]) |
                      (size[1] & (alu_result_m[1:0] != 2'b00));
  assign take = start & ~misaligned;
`else
  assign take = start;
`endif

  // Offset snapped to the natural boundary of the access size; for aligned
  // accesses this is just the address offset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    eff_off   = 2'b00;
    be_nxt    = 4'b1111;
    wdata_nxt = data_w_m;
    unique case (size)
      2'b00: begin
        eff_off   = alu_result_m[1:0];
        be_nxt    = 4'b0001 << alu_result_m[1:0];
        wdata_nxt = {4{data_w_m[7:0]}};
      end
      2'b01: begin
        eff_off   = {alu_result_m[1], 1'b0};
        be_nxt    = 4'b0011 << {alu_result_m[1], 1'b0};
        wdata_nxt = {2{data_w_m[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction using the offset latched at access start.
  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data = mem_rdata;   // W and undefined encodings
    unique case (funct3_q)
      3'b000:  ld_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'd0, rd_shift[7:0]};
      3'b101:  ld_data = {16'd0, rd_shift[15:0]};
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take)    state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = RESP;
      RESP:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state. stall_o covers the start cycle so the
  // instruction is held until its RESP cycle lets the pipeline advance.
  always_comb begin
    mem_req    = (state == BUSY);
    stall_o    = (state == BUSY) | ((state == IDLE) & take);
    wb_valid_o = (state == RESP) & ~mem_we;
  end

  // Request and response registers. Bus outputs only change on the IDLE
  // start edge, so they stay stable for the whole BUSY period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      wb_rd_o   <= 5'd0;
      wb_data_o <= '0;
    end else begin
      if ((state == IDLE) && take) begin
        mem_we    <= mem_write_m;   // read+write together counts as a store
        mem_addr  <= {alu_result_m[ADDR_W-1:2], 2'b00};
        mem_wdata <= wdata_nxt;
        mem_be    <= be_nxt;
        funct3_q  <= funct3_m;
        off_q     <= eff_off;
        wb_rd_o   <= rd_m;
      end
      if ((state == BUSY) && mem_ack && !mem_we)
        wb_data_o <= ld_data;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_o <= 1'b0;
    else       misalign_o <= (state == IDLE) & start & misaligned;
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a table of access vectors with a
// load-result scoreboard, plus hand-written reset and misalignment sequences.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, data_w_m;
  logic [4:0]  rd_m;
  logic        stall_o, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        misalign_o;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .mem_read_m(mem_read_m),
    .mem_write_m(mem_write_m), .funct3_m(funct3_m), .alu_result_m(alu_result_m),
    .data_w_m(data_w_m), .rd_m(rd_m), .stall_o(stall_o), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid_o(wb_valid_o),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;      // BUSY cycle in which mem_ack is driven (>=1)
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  vec_t vecs[$];
  wb_t  sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [4:0] rd, input logic [31:0] rdat,
                              input int d, input logic [3:0] be,
                              input logic [31:0] ea, input logic [31:0] ewd,
                              input logic [31:0] eld);
    vec_t v;
    v.rd_en = r; v.wr_en = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.rd = rd;
    v.rdata = rdat; v.delay = d; v.exp_be = be; v.exp_addr = ea;
    v.exp_wdata = ewd; v.exp_load = eld;
    return v;
  endfunction

  // Writeback monitor: every wb_valid_o pulse must match the oldest load.
  always @(negedge clk) begin
    if (wb_valid_o) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", wb_valid_o, 1'b0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_data", wb_data_o, e.data);
        check("wb_rd", wb_rd_o, e.rd);
      end
    end
  end

  task automatic idle_inputs();
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
  endtask

  task automatic do_access(input vec_t v, input string name);
    int  stall_cnt;
    bit  is_load;
    is_load = v.rd_en && !v.wr_en;
    @(negedge clk);
    valid_m = 1'b1; mem_read_m = v.rd_en; mem_write_m = v.wr_en;
    funct3_m = v.f3; alu_result_m = v.addr; data_w_m = v.wdata; rd_m = v.rd;
    if (is_load) sb.push_back('{v.exp_load, v.rd});
    #1;
    stall_cnt = stall_o ? 1 : 0;
    check({name, " req_in_idle"}, mem_req, 1'b0);
    for (int k = 1; k <= v.delay; k++) begin
      @(negedge clk);
      check({name, " bus"}, {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
            {1'b1, v.wr_en, v.exp_be, v.exp_addr, v.exp_wdata});
      if (stall_o) stall_cnt++;
      mem_rdata = (k == v.delay) ? v.rdata : ~v.rdata;
      mem_ack   = (k == v.delay);
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
    @(negedge clk);  // RESP cycle
    check({name, " resp_req_stall"}, {mem_req, stall_o, misalign_o}, 3'b000);
    check({name, " resp_wb_valid"}, wb_valid_o, is_load);
    idle_inputs();
    #1;
    check({name, " stall_cycles"}, stall_cnt, 1 + v.delay);
    check({name, " wb_done"}, sb.size(), 0);
  endtask

  initial begin
    // {rd, wr, f3, addr, wdata, rd, rdata, delay, be, bus addr, bus wdata, load}
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_1004, 32'h0, 5'd5, 32'hDEAD_BEEF, 1,
                      4'b1111, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 32'h80FF_0000, 1,
                      4'b1000, 32'h0000_1000, 32'h0, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_1003, 32'h0, 5'd8, 32'h80FF_0000, 1,
                      4'b1000, 32'h0000_1000, 32'h0, 32'h0000_0080));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_1002, 32'h1234_56AB, 5'd3, 32'h0, 1,
                      4'b0100, 32'h0000_1000, 32'hABAB_ABAB, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_1002, 32'h0000_BEEF, 5'd4, 32'h0, 4,
                      4'b1100, 32'h0000_1000, 32'hBEEF_BEEF, 32'h0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_1002, 32'h0, 5'd10, 32'h80FF_0000, 2,
                      4'b1100, 32'h0000_1000, 32'h0, 32'hFFFF_80FF));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_1000, 32'h0, 5'd31, 32'h1234_F00D, 3,
                      4'b0011, 32'h0000_1000, 32'h0, 32'h0000_F00D));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_1002, 32'h0, 5'd12, 32'hABCD_1234, 1,
                      4'b1100, 32'h0000_1000, 32'h0, 32'h0000_ABCD));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_1001, 32'h0, 5'd13, 32'h0000_7F00, 1,
                      4'b0010, 32'h0000_1000, 32'h0, 32'h0000_007F));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_2000, 32'h0, 5'd0, 32'h55AA_55AA, 1,
                      4'b1111, 32'h0000_2000, 32'h0, 32'h55AA_55AA));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_3008, 32'hCAFE_F00D, 5'd1, 32'h0, 2,
                      4'b1111, 32'h0000_3008, 32'hCAFE_F00D, 32'h0));
    vecs.push_back(mk(1, 1, 3'b000, 32'h0000_1001, 32'h0000_0077, 5'd2, 32'h0, 1,
                      4'b0010, 32'h0000_1000, 32'h7777_7777, 32'h0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0000_100C, 32'h0, 5'd6, 32'h0102_0304, 1,
                      4'b1111, 32'h0000_100C, 32'h0, 32'h0102_0304));

    reset = 1'b1; idle_inputs(); funct3_m = 3'b000; alu_result_m = '0;
    data_w_m = '0; rd_m = '0; mem_ack = 1'b0; mem_rdata = '0;
    #13;
    check("reset_outputs",
          {mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid_o, wb_data_o,
           wb_rd_o, misalign_o, stall_o}, 110'd0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) do_access(vecs[i], $sformatf("vec%0d", i));

    // Reset while BUSY: the request drops at once and a late ack is ignored.
    @(negedge clk);
    valid_m = 1'b1; mem_read_m = 1'b1; funct3_m = 3'b010;
    alu_result_m = 32'h0000_1004; rd_m = 5'd9;
    @(negedge clk);
    check("rst_busy_req", mem_req, 1'b1);
    #2 reset = 1'b1; idle_inputs();
    #1 check("rst_async", {mem_req, stall_o, mem_addr, mem_be}, 38'd0);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check("rst_late_ack", {mem_req, stall_o, wb_valid_o}, 3'b000);
    do_access(mk(1, 0, 3'b010, 32'h0000_1004, 32'h0, 5'd9, 32'h1357_9BDF, 1,
                 4'b1111, 32'h0000_1004, 32'h0, 32'h1357_9BDF), "after_reset");

`ifdef LSU_MISALIGN_TRAP_EN
    // LW at 0x1002 is refused: no stall, no request, one misalign_o pulse.
    @(negedge clk);
    valid_m = 1'b1; mem_read_m = 1'b1; funct3_m = 3'b010;
    alu_result_m = 32'h0000_1002; rd_m = 5'd11;
    #1 check("mis_stall", {stall_o, misalign_o}, 2'b00);
    @(negedge clk);
    check("mis_pulse", {misalign_o, mem_req, stall_o}, 3'b100);
    idle_inputs();
    @(negedge clk);
    check("mis_end", {misalign_o, mem_req, stall_o, wb_valid_o}, 4'b0000);
`else
    // Misaligned LW falls back to the word boundary.
    do_access(mk(1, 0, 3'b010, 32'h0000_1002, 32'h0, 5'd11, 32'h1122_3344, 1,
                 4'b1111, 32'h0000_1000, 32'h0, 32'h1122_3344), "mis_lw");
    do_access(mk(0, 1, 3'b001, 32'h0000_1003, 32'h0000_A5C3, 5'd1, 32'h0, 1,
                 4'b1100, 32'h0000_1000, 32'hA5C3_A5C3, 32'h0), "mis_sh");
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
